// File: rtl/mailbox_pkg.sv
// Shared definitions for the mailbox responder: register map, FSM states, STATUS layout.
package mailbox_pkg;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h1;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_FLUSH  = 4'h3;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 16;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // STATUS word: {count[15:0], 14'b0, full, empty}
  function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[STATUS_COUNT_LSB +: 16] = cnt;
    w[STATUS_FULL_BIT]        = full;
    w[STATUS_EMPTY_BIT]       = empty;
    return w;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Single-clock show-ahead FIFO backing one CPU's receive mailbox.
module mbox_fifo #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(D+1)-1:0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = $clog2(D+1);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == CW'(D));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointer and occupancy update; the top guarantees at most one event per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_push_ok) begin
      r_wptr  <= r_wptr + 1'b1;
      r_count <= r_count + 1'b1;
    end else if (w_pop_ok) begin
      r_rptr  <= r_rptr + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/mailbox_resp.sv
// Mailbox responder: decodes the arbitrated request, services per-CPU FIFOs, and
// returns data/error with a four-phase one-hot ack.
module mailbox_resp
  import mailbox_pkg::*;
#(
  parameter int unsigned W_WIDTH_SYS = 32,
  parameter int unsigned N_NUMB_CPU  = 4,
  parameter int unsigned D_DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_NUMB_CPU-1:0]  req_i,
  input  logic [W_WIDTH_SYS-1:0] addr_i,
  input  logic [W_WIDTH_SYS-1:0] data_i,
  input  logic                   write_i,
  input  logic [31:0]            numb_cpu_i,
  output logic [W_WIDTH_SYS-1:0] rdata_o,
  output logic                   err_o,
  output logic [N_NUMB_CPU-1:0]  ack_o,
  output logic [N_NUMB_CPU-1:0]  irq_o
);

  localparam int unsigned IW = $clog2(N_NUMB_CPU);
  localparam int unsigned CW = $clog2(D_DEPTH+1);

  state_t                 r_state, w_state_d;
  logic [W_WIDTH_SYS-1:0] r_rdata, w_rdata_d;
  logic                   r_err, w_err_d;
  logic [N_NUMB_CPU-1:0]  r_ack, w_ack_d;

  logic [N_NUMB_CPU-1:0]  w_push, w_pop, w_flush;
  logic [N_NUMB_CPU-1:0]  w_full, w_empty;
  logic [W_WIDTH_SYS-1:0] w_head  [N_NUMB_CPU];
  logic [CW-1:0]          w_count [N_NUMB_CPU];

  logic [3:0]             w_reg;
  logic [3:0]             w_tgt;
  logic [IW-1:0]          w_self;
  logic [IW-1:0]          w_tgt_idx;
  logic                   w_req;
  logic                   w_cpu_ok;
  logic                   w_tgt_ok;
  logic                   w_unused;

  assign w_reg     = addr_i[11:8];
  assign w_tgt     = addr_i[3:0];
  assign w_self    = numb_cpu_i[IW-1:0];
  assign w_tgt_idx = w_tgt[IW-1:0];
  assign w_req     = |req_i;
  assign w_cpu_ok  = (numb_cpu_i < N_NUMB_CPU);
  assign w_tgt_ok  = (32'(w_tgt) < N_NUMB_CPU);

  // Address bits outside reg/tgt and upper CPU-index bits are intentionally ignored.
  assign w_unused = ^{addr_i[W_WIDTH_SYS-1:12], addr_i[7:4], numb_cpu_i[31:IW]};

  assign rdata_o = r_rdata;
  assign err_o   = r_err;
  assign ack_o   = r_ack;
  assign irq_o   = ~w_empty;

  for (genvar g = 0; g < N_NUMB_CPU; g++) begin : g_fifo
    mbox_fifo #(
      .W (W_WIDTH_SYS),
      .D (D_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .flush (w_flush[g]),
      .wdata (data_i),
      .rdata (w_head[g]),
      .count (w_count[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  // Next-state, FIFO strobes and response values; one FIFO action per handshake.
  always_comb begin
    w_state_d = r_state;
    w_rdata_d = r_rdata;
    w_err_d   = r_err;
    w_ack_d   = r_ack;
    w_push    = '0;
    w_pop     = '0;
    w_flush   = '0;
    unique case (r_state)
      IDLE: begin
        w_err_d = 1'b0;
        w_ack_d = '0;
        if (w_req && !w_cpu_ok) begin
          // Bad requester: error pulse only, no ack, no FIFO action.
          w_err_d = 1'b1;
        end else if (w_req) begin
          w_state_d = HOLD;
          w_ack_d   = N_NUMB_CPU'(1) << w_self;
          w_rdata_d = '0;
          w_err_d   = 1'b1;
          unique case (w_reg)
            REG_TXDATA: begin
              if (write_i && w_tgt_ok && !w_full[w_tgt_idx]) begin
                w_push[w_tgt_idx] = 1'b1;
                w_err_d           = 1'b0;
              end
            end
            REG_RXDATA: begin
              if (!write_i && !w_empty[w_self]) begin
                w_pop[w_self] = 1'b1;
                w_rdata_d     = w_head[w_self];
                w_err_d       = 1'b0;
              end
            end
            REG_STATUS: begin
              if (!write_i) begin
                w_rdata_d = W_WIDTH_SYS'(status_word(16'(w_count[w_self]), w_full[w_self],
                                                     w_empty[w_self]));
                w_err_d   = 1'b0;
              end
            end
            REG_FLUSH: begin
              if (write_i) begin
                w_flush[w_self] = 1'b1;
                w_err_d         = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        if (!w_req) begin
          w_state_d = IDLE;
          w_ack_d   = '0;
          w_err_d   = 1'b0;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Response and state registers; reset drops ack/err immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_d;
      r_rdata <= w_rdata_d;
      r_err   <= w_err_d;
      r_ack   <= w_ack_d;
    end
  end

endmodule

// File: tb/tb_mailbox_resp.sv
// Scoreboard bench for mailbox_resp: driver queues expected responses, monitor checks on ack.
module tb_mailbox_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic        write_i = 1'b0;
  logic [31:0] numb_cpu_i = '0;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [3:0]  ack_o;
  logic [3:0]  irq_o;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [3:0]  ack;
    logic        chk;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic seen  = 1'b0;

  mailbox_resp #(
    .W_WIDTH_SYS (32),
    .N_NUMB_CPU  (4),
    .D_DEPTH     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .write_i    (write_i),
    .numb_cpu_i (numb_cpu_i),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .ack_o      (ack_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  // Monitor: on each new ack, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (ack_o != 4'b0 && !seen) begin
        seen = 1'b1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack got ack=%b err=%b rdata=%h want no response",
                   ack_o, err_o, rdata_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ack_o !== e.ack || err_o !== e.err || (e.chk && rdata_o !== e.rd)) begin
            bad++;
            $display("FAIL response got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                     ack_o, err_o, rdata_o, e.ack, e.err, e.rd);
          end
        end
      end
      if (ack_o == 4'b0) seen = 1'b0;
    end else begin
      seen = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Issue one request and wait (bounded) for its ack; optionally leave it held.
  task automatic issue(input int cpu, input logic [31:0] addr, input logic [31:0] data,
                       input logic wr, input logic [31:0] exp_rd, input logic exp_err,
                       input logic chk, input logic release_req);
    exp_t e;
    logic got;
    e.rd = exp_rd; e.err = exp_err; e.ack = 4'(1 << cpu); e.chk = chk;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_i = 4'(1 << cpu); addr_i = addr; data_i = data; write_i = wr; numb_cpu_i = cpu;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack_o != 4'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout got ack=%b want ack=%b", ack_o, e.ack);
      if (exp_q.size() > 0) exp_q.delete(0);
    end
    if (release_req) begin
      req_i = '0;
      @(posedge clk); #1;
      check("ack_release", {27'b0, err_o, ack_o}, 32'h0);
    end
  endtask

  task automatic tx(input int cpu, input int tgt, input logic [31:0] d, input logic e);
    issue(cpu, 32'(tgt), d, 1'b1, 32'h0, e, 1'b0, 1'b1);
  endtask

  task automatic rx(input int cpu, input logic [31:0] d, input logic e);
    issue(cpu, 32'h100, 32'h0, 1'b0, d, e, 1'b1, 1'b1);
  endtask

  task automatic stat(input int cpu, input logic [31:0] s);
    issue(cpu, 32'h200, 32'h0, 1'b0, s, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #1;
    check("reset_outputs", {rdata_o[27:0], err_o, ack_o[2:0]}, 32'h0);
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_ack_irq", {24'b0, ack_o, irq_o}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Basic push / pop / underflow
    tx(1, 0, 32'hDEAD_BEEF, 1'b0);
    check("irq_after_push", {28'b0, irq_o}, 32'h1);
    issue(0, 32'hABC0_F100, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    check("irq_after_pop", {28'b0, irq_o}, 32'h0);
    rx(0, 32'h0, 1'b1);

    // Fill FIFO3 to overflow, then drain in order
    for (int i = 1; i <= 9; i++) tx(2, 3, 32'(100 + i), (i == 9));
    stat(3, 32'h0008_0002);
    check("irq_full", {28'b0, irq_o}, 32'h8);
    for (int i = 1; i <= 8; i++) rx(3, 32'(100 + i), 1'b0);
    stat(3, 32'h0000_0001);

    // Ordering across pointer wrap on FIFO2
    for (int i = 0; i <= 7; i++) tx(0, 2, 32'(i), 1'b0);
    for (int i = 0; i <= 2; i++) rx(2, 32'(i), 1'b0);
    for (int i = 8; i <= 10; i++) tx(0, 2, 32'(i), 1'b0);
    stat(2, 32'h0008_0002);
    for (int i = 3; i <= 10; i++) rx(2, 32'(i), 1'b0);
    stat(2, 32'h0000_0001);

    // Flush with 5 words queued
    for (int i = 0; i < 5; i++) tx(1, 3, 32'(200 + i), 1'b0);
    stat(3, 32'h0005_0000);
    check("irq_before_flush", {28'b0, irq_o}, 32'h8);
    issue(3, 32'h300, 32'h1234, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    stat(3, 32'h0000_0001);
    check("irq_after_flush", {28'b0, irq_o}, 32'h0);

    // Access errors
    tx(0, 1, 32'h55, 1'b0);
    issue(1, 32'h200, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    issue(1, 32'h000, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    issue(1, 32'h100, 32'h9, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    issue(1, 32'h300, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    issue(1, 32'h400, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    tx(1, 5, 32'h77, 1'b1);
    stat(1, 32'h0001_0000);

    // Out-of-range requester: single err pulse, no ack
    @(posedge clk); #1;
    req_i = 4'b0001; addr_i = 32'h000; write_i = 1'b1; data_i = 32'h1; numb_cpu_i = 7;
    @(posedge clk); #1;
    check("bad_cpu_err", {27'b0, err_o, ack_o}, 32'h10);
    req_i = '0;
    @(posedge clk); #1;
    check("bad_cpu_err_clear", {27'b0, err_o, ack_o}, 32'h0);
    stat(1, 32'h0001_0000);

    // Reset while in HOLD
    tx(2, 0, 32'hCAFE, 1'b0);
    issue(0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1; req_i = '0;
    #1;
    check("reset_in_hold", {27'b0, err_o, ack_o}, 32'h0);
    check("reset_irq", {28'b0, irq_o}, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) stat(c, 32'h0000_0001);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mailbox_resp.md
Name: mailbox_resp

Overview:
- Responder end of the mailbox bus: takes the single arbitrated request stream produced by the CPU-side arbiter and services it.
- Holds one receive FIFO per CPU and returns read data, an error flag and a per-CPU ack over a four-phase req/ack handshake.
- Sender-side TXDATA writes push into the destination CPU's FIFO; the owner drains it via RXDATA reads.
- Raises a per-CPU not-empty interrupt.

Parameters:
- W_WIDTH_SYS, 32, data/address width.
- N_NUMB_CPU, 4, number of CPUs/mailboxes (2..16).
- D_DEPTH, 8, words per mailbox FIFO (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_i  in  N_NUMB_CPU  request from arbiter; request present when any bit set.
- addr_i  in  W_WIDTH_SYS  word address.
- data_i  in  W_WIDTH_SYS  write data.
- write_i  in  1  1=write, 0=read.
- numb_cpu_i  in  32  index of requesting CPU.
- rdata_o  out  W_WIDTH_SYS  read data, valid while ack high.
- err_o  out  1  access error, valid while ack high.
- ack_o  out  N_NUMB_CPU  one-hot ack to requesting CPU.
- irq_o  out  N_NUMB_CPU  bit i = FIFO[i] not empty.

Behaviour:
- Reset (async, rst=1): state IDLE; rdata_o=0, err_o=0, ack_o=0; all FIFOs empty, so irq_o=0.
- Address decode: reg=addr_i[11:8], tgt=addr_i[3:0]; all other address bits ignored.
  - reg 0x0 TXDATA: write only; push data_i into FIFO[tgt]; tgt==numb_cpu_i (loopback) allowed.
  - reg 0x1 RXDATA: read only; pop FIFO[numb_cpu_i]; rdata_o=head word.
  - reg 0x2 STATUS: read only; rdata_o = {zero-extended count[15:0], 14'b0, full, empty} of FIFO[numb_cpu_i].
  - reg 0x3 FLUSH: write only; empties FIFO[numb_cpu_i]; data ignored.
  - Any other reg value: error.
- FSM: IDLE, HOLD.
  - IDLE, |req_i=1, numb_cpu_i<N_NUMB_CPU:
    - Perform the access at this edge.
    - Register rdata_o/err_o; ack_o = one-hot(numb_cpu_i); go to HOLD.
    - Latency: ack one cycle after req is sampled.
  - IDLE, |req_i=1, numb_cpu_i>=N_NUMB_CPU:
    - No FIFO action, no ack.
    - err_o pulses 1 for one cycle; stay in IDLE.
  - HOLD, |req_i=1: hold ack_o, rdata_o, err_o stable. No further action; exactly one action per handshake.
  - HOLD, |req_i=0: ack_o=0, err_o=0, go to IDLE. rdata_o keeps its last value.
- Error cases (err_o=1 with ack; FIFO unchanged; rdata_o=0):
  - push to full FIFO;
  - pop from empty FIFO;
  - tgt>=N_NUMB_CPU on TXDATA;
  - wrong direction (read TXDATA/FLUSH, write RXDATA/STATUS);
  - unmapped reg.
- FIFO rules:
  - Pointers wrap modulo D_DEPTH.
  - count width $clog2(D_DEPTH+1); full when count==D_DEPTH.
  - Only one push, pop or flush per cycle by construction, so there are no simultaneous FIFO events.
- irq_o is combinational from each FIFO's empty flag. It updates the cycle after a push/pop/flush.
- Reset mid-handshake: ack_o and err_o drop immediately and FIFO contents are lost. The arbiter must re-issue the request.

Decomposition:
- Package mailbox_pkg:
  - reg offsets REG_TXDATA=4'h0, REG_RXDATA=4'h1, REG_STATUS=4'h2, REG_FLUSH=4'h3;
  - FSM enum {IDLE, HOLD};
  - STATUS bit positions.
- Sub-module mbox_fifo:
  - parameters W, D;
  - ports push, pop, flush, wdata, rdata (head, show-ahead), count, full, empty;
  - one instance per CPU, generated.

Test Plan:
- CPU1 writes 0xDEAD_BEEF to addr 0x000 (tgt 0); hold req until ack_o=4'b0010, then drop req -> ack falls next cycle, err_o=0, irq_o=4'b0001.
- CPU0 reads 0x100 -> rdata_o=0xDEAD_BEEF, err_o=0, ack_o=4'b0001; after req drops, irq_o=0. A second read -> err_o=1, rdata_o=0.
- CPU2 pushes 9 words to tgt 3 (D_DEPTH=8) -> pushes 1..8 ok; 9th gives err_o=1; CPU3 STATUS read = 0x0008_0002 (count=8, full=1).
- Order/wrap: push 0..7, pop 3, push 8..10, pop all -> rdata sequence 0..10 in order, final STATUS=0x0000_0001.
- CPU3 writes FLUSH 0x300 with 5 words queued -> STATUS=1, irq_o[3]=0. Write to 0x200 -> err_o=1. numb_cpu_i=7 -> err_o pulse, ack_o=0.
- Assert rst while in HOLD -> ack_o/err_o=0 in the same cycle; next STATUS read on all CPUs = 0x0000_0001.
